// File: rtl/cbfp_block_norm.sv
// cbfp_block_norm: ping-pong CBFP normaliser; finds one common left shift per LANES x BEATS
// block and replays the block shifted, rounded half-up and saturated to OUT_W bits.
module cbfp_block_norm #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 11,
  parameter int LANES = 16,
  parameter int BEATS = 4,
  parameter int EXP_W = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         valid_in,
  input  logic                         norm_en,
  input  logic [LANES-1:0][IN_W-1:0]   din_R,
  input  logic [LANES-1:0][IN_W-1:0]   din_Q,
  output logic                         valid_out,
  output logic                         blk_first,
  output logic                         blk_last,
  output logic [LANES-1:0][OUT_W-1:0]  dout_R,
  output logic [LANES-1:0][OUT_W-1:0]  dout_Q,
  output logic [EXP_W-1:0]             exp_out
);
  localparam int D = IN_W - OUT_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [EXP_W-1:0] LS_MAX = EXP_W'(IN_W - 1);
  localparam logic [IN_W:0] RND = (IN_W + 1)'(1) << (D - 1);

  function automatic logic [EXP_W-1:0] f_ls(input logic [IN_W-1:0] x);
    logic run;
    f_ls = '0;
    run = 1'b1;
    for (int i = IN_W - 2; i >= 0; i--) begin
      run = run & (x[i] == x[IN_W-1]);
      f_ls = f_ls + EXP_W'(run);
    end
  endfunction

  function automatic logic [EXP_W-1:0] f_min(input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b);
    f_min = (a < b) ? a : b;
  endfunction

  // shift cannot overflow (s never exceeds the block's sign run); the extra MSB absorbs the rounding carry
  function automatic logic [OUT_W-1:0] f_norm(input logic [IN_W-1:0] x, input logic [EXP_W-1:0] s);
    logic [IN_W-1:0] sh;
    logic [OUT_W:0] r;
    sh = x << s;
    r = (OUT_W + 1)'(({sh[IN_W-1], sh} + RND) >> D);
    f_norm = (r[OUT_W] != r[OUT_W-1]) ? {r[OUT_W], {(OUT_W - 1){~r[OUT_W]}}} : r[OUT_W-1:0];
  endfunction

  logic [LANES-1:0][IN_W-1:0] r_buf_R [2][BEATS];
  logic [LANES-1:0][IN_W-1:0] r_buf_Q [2][BEATS];
  logic [CW-1:0]              r_wr_cnt;
  logic [CW-1:0]              r_rd_cnt;
  logic                       r_wsel;
  logic                       r_rsel;
  logic [1:0]                 r_full;
  logic [EXP_W-1:0]           r_s [2];
  logic [EXP_W-1:0]           r_min;
  logic                       r_en;

  logic [EXP_W-1:0]           w_beat_min;
  logic [EXP_W-1:0]           w_min;
  logic                       w_en;
  logic                       w_done;
  logic                       w_rd;
  logic                       w_rd_last;
  logic [1:0]                 w_full;
  logic [LANES-1:0][OUT_W-1:0] w_nr;
  logic [LANES-1:0][OUT_W-1:0] w_nq;

  always_comb begin
    w_beat_min = LS_MAX;
    for (int i = 0; i < LANES; i++) begin
      w_beat_min = f_min(w_beat_min, f_ls(din_R[i]));
      w_beat_min = f_min(w_beat_min, f_ls(din_Q[i]));
    end
  end

  assign w_min     = (r_wr_cnt == '0) ? w_beat_min : f_min(r_min, w_beat_min);
  assign w_en      = (r_wr_cnt == '0) ? norm_en : r_en;
  assign w_done    = valid_in && (r_wr_cnt == LAST);
  assign w_rd      = r_full[r_rsel];
  assign w_rd_last = w_rd && (r_rd_cnt == LAST);

  // a drain finishing and a fill completing can coincide on different buffers
  always_comb begin
    w_full = r_full;
    if (w_rd_last) w_full[r_rsel] = 1'b0;
    if (w_done) w_full[r_wsel] = 1'b1;
  end

  always_comb begin
    w_nr = '0;
    w_nq = '0;
    for (int i = 0; i < LANES; i++) begin
      w_nr[i] = f_norm(r_buf_R[r_rsel][r_rd_cnt][i], r_s[r_rsel]);
      w_nq[i] = f_norm(r_buf_Q[r_rsel][r_rd_cnt][i], r_s[r_rsel]);
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_buf_R[r_wsel][r_wr_cnt] <= din_R;
      r_buf_Q[r_wsel][r_wr_cnt] <= din_Q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_wsel    <= 1'b0;
      r_rsel    <= 1'b0;
      r_full    <= '0;
      r_s       <= '{default: '0};
      r_min     <= '0;
      r_en      <= 1'b0;
      valid_out <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      dout_R    <= '0;
      dout_Q    <= '0;
      exp_out   <= '0;
    end else begin
      if (valid_in) begin
        r_wr_cnt <= w_done ? '0 : r_wr_cnt + CW'(1);
        r_min    <= w_min;
        r_en     <= w_en;
      end
      if (w_done) begin
        r_s[r_wsel] <= w_en ? w_min : '0;
        r_wsel      <= ~r_wsel;
      end
      if (w_rd) r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CW'(1);
      if (w_rd_last) r_rsel <= ~r_rsel;
      r_full    <= w_full;
      valid_out <= w_rd;
      blk_first <= w_rd && (r_rd_cnt == '0);
      blk_last  <= w_rd_last;
      dout_R    <= w_rd ? w_nr : '0;
      dout_Q    <= w_rd ? w_nq : '0;
      exp_out   <= w_rd ? r_s[r_rsel] : '0;
    end
  end
endmodule

// File: tb/tb_cbfp_block_norm.sv
// tb_cbfp_block_norm: directed stimulus with a scoreboard of expected output beats,
// each tagged with the exact cycle it must appear in.
module tb_cbfp_block_norm;
  localparam int IN_W  = 23;
  localparam int OUT_W = 11;
  localparam int LANES = 16;
  localparam int BEATS = 4;
  localparam int EXP_W = 5;
  localparam int D     = IN_W - OUT_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic valid_in = 1'b0;
  logic norm_en = 1'b0;
  logic [LANES-1:0][IN_W-1:0]  din_R = '0;
  logic [LANES-1:0][IN_W-1:0]  din_Q = '0;
  logic                        valid_out;
  logic                        blk_first;
  logic                        blk_last;
  logic [LANES-1:0][OUT_W-1:0] dout_R;
  logic [LANES-1:0][OUT_W-1:0] dout_Q;
  logic [EXP_W-1:0]            exp_out;

  typedef struct packed {
    int                          cyc;
    logic [EXP_W-1:0]            e;
    logic                        first;
    logic                        last;
    logic [LANES-1:0][OUT_W-1:0] r;
    logic [LANES-1:0][OUT_W-1:0] q;
  } exp_t;

  exp_t sbq[$];
  int bR[BEATS][LANES];
  int bQ[BEATS][LANES];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  cbfp_block_norm #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .BEATS(BEATS), .EXP_W(EXP_W)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .norm_en(norm_en),
    .din_R(din_R), .din_Q(din_Q), .valid_out(valid_out), .blk_first(blk_first),
    .blk_last(blk_last), .dout_R(dout_R), .dout_Q(dout_Q), .exp_out(exp_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit fits(input int v, input int t);
    longint y;
    y = longint'(v) <<< t;
    return (y <= (longint'(1) << (IN_W - 1)) - 1) && (y >= -(longint'(1) << (IN_W - 1)));
  endfunction

  // largest shift that keeps every sample of the block inside IN_W bits
  function automatic int m_shift(input bit ne);
    int s;
    bit ok;
    s = 0;
    if (!ne) return 0;
    for (int t = 0; t < IN_W; t++) begin
      ok = 1'b1;
      for (int b = 0; b < BEATS; b++)
        for (int i = 0; i < LANES; i++)
          if (!fits(bR[b][i], t) || !fits(bQ[b][i], t)) ok = 1'b0;
      if (ok) s = t;
    end
    return s;
  endfunction

  function automatic int m_out(input int v, input int s);
    longint r;
    r = ((longint'(v) <<< s) + (longint'(1) << (D - 1))) >>> D;
    if (r > (1 << (OUT_W - 1)) - 1) return (1 << (OUT_W - 1)) - 1;
    if (r < -(1 << (OUT_W - 1))) return -(1 << (OUT_W - 1));
    return int'(r);
  endfunction

  task automatic clr();
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < LANES; i++) begin
        bR[b][i] = 0;
        bQ[b][i] = 0;
      end
  endtask

  task automatic fill_rand(input int m);
    for (int b = 0; b < BEATS; b++)
      for (int i = 0; i < LANES; i++) begin
        bR[b][i] = int'($urandom_range(0, 2 * m)) - m;
        bQ[b][i] = int'($urandom_range(0, 2 * m)) - m;
      end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      norm_en = 1'b0;
      din_R = '0;
      din_Q = '0;
    end
  endtask

  // norm_en is flipped after beat 0 to prove only beat 0 counts; gap cycles carry garbage
  task automatic send_block(input bit ne, input int gap, input int nb);
    exp_t x;
    int s;
    for (int b = 0; b < nb; b++) begin
      if (b > 0)
        repeat (gap) begin
          @(negedge clk);
          valid_in = 1'b0;
          norm_en = 1'($urandom_range(0, 1));
          for (int i = 0; i < LANES; i++) begin
            din_R[i] = IN_W'($urandom);
            din_Q[i] = IN_W'($urandom);
          end
        end
      @(negedge clk);
      valid_in = 1'b1;
      norm_en = (b == 0) ? ne : !ne;
      for (int i = 0; i < LANES; i++) begin
        din_R[i] = IN_W'(bR[b][i]);
        din_Q[i] = IN_W'(bQ[b][i]);
      end
    end
    if (nb == BEATS) begin
      s = m_shift(ne);
      for (int k = 0; k < BEATS; k++) begin
        x.cyc = cyc + 2 + k;
        x.e = EXP_W'(s);
        x.first = (k == 0);
        x.last = (k == BEATS - 1);
        for (int i = 0; i < LANES; i++) begin
          x.r[i] = OUT_W'(m_out(bR[k][i], s));
          x.q[i] = OUT_W'(m_out(bQ[k][i], s));
        end
        sbq.push_back(x);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (valid_out) begin
      if (sbq.size() == 0) chk("unexpected_valid_out", 1, 0);
      else begin
        x = sbq.pop_front();
        chk("beat_cycle", cyc, x.cyc);
        chk("exp_out", exp_out, x.e);
        chk("blk_first", blk_first, x.first);
        chk("blk_last", blk_last, x.last);
        for (int i = 0; i < LANES; i++) begin
          chk("dout_R", $signed(dout_R[i]), $signed(x.r[i]));
          chk("dout_Q", $signed(dout_Q[i]), $signed(x.q[i]));
        end
      end
    end else chk("idle_outputs_zero", |{blk_first, blk_last, exp_out, dout_R, dout_Q}, 0);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    #1;
    chk("reset_valid_out", valid_out, 0);
    chk("reset_exp_out", exp_out, 0);
    chk("reset_dout", |{dout_R, dout_Q, blk_first, blk_last}, 0);
    idle(3);
    rstn = 1'b1;
    idle(3);
    clr();
    bR[2][0] = 5;
    send_block(1'b1, 0, BEATS);
    idle(6);
    clr();
    send_block(1'b1, 0, BEATS);
    send_block(1'b0, 0, BEATS);
    idle(6);
    clr();
    bR[0][0] = -4194304;
    bR[0][1] = 4194303;
    bR[1][0] = 2047;
    bR[1][1] = 2048;
    bQ[3][14] = -2048;
    bQ[3][15] = -2049;
    send_block(1'b1, 0, BEATS);
    idle(6);
    fill_rand(100);
    bR[1][3] = 100;
    send_block(1'b1, 0, BEATS);
    fill_rand(1000000);
    bQ[2][7] = 1000000;
    send_block(1'b1, 0, BEATS);
    idle(2);
    fill_rand(3000);
    send_block(1'b1, 2, BEATS);
    idle(8);
    fill_rand(50000);
    send_block(1'b1, 0, 2);
    @(negedge clk);
    valid_in = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    fill_rand(20000);
    send_block(1'b1, 0, BEATS);
    idle(6);
    fill_rand(700);
    send_block(1'b1, 0, BEATS);
    idle(1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_valid_out", valid_out, 0);
    chk("async_reset_exp_out", exp_out, 0);
    chk("async_reset_dout", |{dout_R, dout_Q, blk_first, blk_last}, 0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    idle(6);
    fill_rand(4000000);
    send_block(1'b1, 1, BEATS);
    idle(2);
    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
